// File: rtl/status_flag_unit.sv
// NZCV flag register with in-flight setter tracking, EX bypass,
// exception shadow copy and condition-check stall generation.
module status_flag_unit #(
    parameter int DEPTH  = 3,
    parameter bit BYPASS = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       id_valid,
    input  logic [3:0]                 id_cond,
    input  logic                       id_issue,
    input  logic                       id_s,
    input  logic                       ex_wr,
    input  logic [3:0]                 ex_status,
    input  logic                       flush,
    input  logic                       save_req,
    input  logic                       restore_req,
    output logic [3:0]                 status_out,
    output logic                       stall,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic [1:0]                 err
);

    localparam int PW = $clog2(DEPTH + 1);
    localparam logic [3:0] COND_AL = 4'b1110;

    logic [3:0]    nzcv_q, nzcv_d;
    logic [3:0]    shadow_q, shadow_d;
    logic [PW-1:0] pend_q, pend_d;
    logic [1:0]    err_q, err_d;

    logic          inc, dec, ovf, unf;
    logic          eff_sub;
    logic [3:0]    status_mux;

    // A restore owns the flag write, so the EX result is not forwarded either.
    assign status_mux = (BYPASS && ex_wr && !restore_req) ? ex_status : nzcv_q;
    assign eff_sub    = BYPASS & ex_wr;

    assign inc = id_issue & id_s & ~flush;
    assign dec = ex_wr;
    assign ovf = inc & ~dec & (pend_q == PW'(DEPTH));
    assign unf = dec & ~inc & (pend_q == '0);

    always_comb begin
        nzcv_d = nzcv_q;
        if (restore_req) begin
            nzcv_d = shadow_q;
        end else if (ex_wr) begin
            nzcv_d = ex_status;
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        if (save_req) begin
            shadow_d = status_mux;
        end
    end

    always_comb begin
        pend_d = pend_q;
        if (flush) begin
            pend_d = '0;
        end else if (inc && !dec) begin
            pend_d = ovf ? pend_q : pend_q + PW'(1);
        end else if (dec && !inc) begin
            pend_d = unf ? pend_q : pend_q - PW'(1);
        end
    end

    assign err_d = err_q | {ovf, unf};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzcv_q   <= '0;
            shadow_q <= '0;
            pend_q   <= '0;
            err_q    <= '0;
        end else begin
            nzcv_q   <= nzcv_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
        end
    end

    // Outputs are forced low while reset is held, even with ex_wr active.
    assign status_out = rst_n ? status_mux : 4'b0000;
    assign stall      = rst_n & id_valid & (id_cond != COND_AL)
                      & (pend_q != PW'(eff_sub));
    assign pending    = pend_q;
    assign err        = err_q;

endmodule

// File: tb/tb_status_flag_unit.sv
// Table-driven bench for status_flag_unit, bypass and registered
// variants side by side, with a scoreboard for post-edge state.
module tb_status_flag_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_issue, id_s, ex_wr;
    logic [3:0] id_cond, ex_status;
    logic       flush, save_req, restore_req;

    logic [3:0] b_out, r_out;
    logic       b_stall, r_stall;
    logic [1:0] b_pend, r_pend;
    logic [1:0] b_err, r_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    status_flag_unit #(.DEPTH(3), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_cond(id_cond),
        .id_issue(id_issue), .id_s(id_s),
        .ex_wr(ex_wr), .ex_status(ex_status),
        .flush(flush), .save_req(save_req),
        .restore_req(restore_req),
        .status_out(b_out), .stall(b_stall),
        .pending(b_pend), .err(b_err)
    );

    status_flag_unit #(.DEPTH(3), .BYPASS(1'b0)) u_reg (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_cond(id_cond),
        .id_issue(id_issue), .id_s(id_s),
        .ex_wr(ex_wr), .ex_status(ex_status),
        .flush(flush), .save_req(save_req),
        .restore_req(restore_req),
        .status_out(r_out), .stall(r_stall),
        .pending(r_pend), .err(r_err)
    );

    typedef struct {
        logic       v;
        logic [3:0] c;
        logic       i, s, w;
        logic [3:0] st;
        logic       f, sv, rr;
        logic [3:0] bo;
        logic       bs;
        logic [3:0] ro;
        logic       rstl;
        logic [1:0] pd, er;
    } vec_t;

    typedef struct {
        logic [1:0] pd, er;
        int         idx;
    } post_t;

    vec_t  tbl[$];
    post_t sb[$];

    function automatic vec_t mk(
        logic v, logic [3:0] c, logic i, logic s, logic w,
        logic [3:0] st, logic f, logic sv, logic rr,
        logic [3:0] bo, logic bs, logic [3:0] ro, logic rstl,
        logic [1:0] pd, logic [1:0] er);
        vec_t r;
        r.v = v; r.c = c; r.i = i; r.s = s; r.w = w; r.st = st;
        r.f = f; r.sv = sv; r.rr = rr;
        r.bo = bo; r.bs = bs; r.ro = ro; r.rstl = rstl;
        r.pd = pd; r.er = er;
        return r;
    endfunction

    task automatic chk(string name, logic [3:0] got, logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic drive(vec_t t);
        id_valid = t.v; id_cond = t.c; id_issue = t.i; id_s = t.s;
        ex_wr = t.w; ex_status = t.st; flush = t.f;
        save_req = t.sv; restore_req = t.rr;
    endtask

    task automatic apply(vec_t t, int idx);
        post_t p;
        @(negedge clk);
        drive(t);
        #1;
        chk($sformatf("r%0d byp_out", idx), b_out, t.bo);
        chk($sformatf("r%0d byp_stall", idx), {3'b0, b_stall}, {3'b0, t.bs});
        chk($sformatf("r%0d reg_out", idx), r_out, t.ro);
        chk($sformatf("r%0d reg_stall", idx), {3'b0, r_stall}, {3'b0, t.rstl});
        p.pd = t.pd; p.er = t.er; p.idx = idx;
        sb.push_back(p);
        @(posedge clk);
        #1;
        p = sb.pop_front();
        chk($sformatf("r%0d byp_pend", p.idx), {2'b0, b_pend}, {2'b0, p.pd});
        chk($sformatf("r%0d reg_pend", p.idx), {2'b0, r_pend}, {2'b0, p.pd});
        chk($sformatf("r%0d byp_err", p.idx), {2'b0, b_err}, {2'b0, p.er});
        chk($sformatf("r%0d reg_err", p.idx), {2'b0, r_err}, {2'b0, p.er});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t t;
        // v  cond  i  s  w  st   f  sv rr | bo bs ro rs | pd er
        tbl.push_back(mk(0,4'h0,0,0,0,4'h0,0,0,0, 4'b0000,0,4'b0000,0, 0,2'b00));
        tbl.push_back(mk(1,4'hE,1,1,0,4'h0,0,0,0, 4'b0000,0,4'b0000,0, 1,2'b00));
        tbl.push_back(mk(1,4'h0,0,0,0,4'h0,0,0,0, 4'b0000,1,4'b0000,1, 1,2'b00));
        tbl.push_back(mk(1,4'h0,0,0,1,4'h4,0,0,0, 4'b0100,0,4'b0000,1, 0,2'b00));
        tbl.push_back(mk(1,4'h0,0,0,0,4'h0,0,0,0, 4'b0100,0,4'b0100,0, 0,2'b00));
        tbl.push_back(mk(1,4'hE,1,1,0,4'h0,0,0,0, 4'b0100,0,4'b0100,0, 1,2'b00));
        tbl.push_back(mk(1,4'hE,1,1,0,4'h0,0,0,0, 4'b0100,0,4'b0100,0, 2,2'b00));
        tbl.push_back(mk(1,4'hE,1,1,0,4'h0,0,0,0, 4'b0100,0,4'b0100,0, 3,2'b00));
        tbl.push_back(mk(1,4'hE,1,1,0,4'h0,0,0,0, 4'b0100,0,4'b0100,0, 3,2'b10));
        tbl.push_back(mk(1,4'h1,0,0,0,4'h0,0,0,0, 4'b0100,1,4'b0100,1, 3,2'b10));
        tbl.push_back(mk(1,4'h1,0,0,1,4'h2,0,0,0, 4'b0010,1,4'b0100,1, 2,2'b10));
        tbl.push_back(mk(1,4'hE,1,1,0,4'h0,1,0,0, 4'b0010,0,4'b0010,0, 0,2'b10));
        tbl.push_back(mk(1,4'hE,0,0,0,4'h0,0,0,0, 4'b0010,0,4'b0010,0, 0,2'b10));
        tbl.push_back(mk(1,4'hE,1,1,0,4'h0,0,0,0, 4'b0010,0,4'b0010,0, 1,2'b10));
        tbl.push_back(mk(0,4'h0,0,0,1,4'hB,1,0,0, 4'b1011,0,4'b0010,0, 0,2'b10));
        tbl.push_back(mk(0,4'h0,0,0,0,4'h0,0,0,0, 4'b1011,0,4'b1011,0, 0,2'b10));
        tbl.push_back(mk(1,4'hE,1,1,0,4'h0,0,0,0, 4'b1011,0,4'b1011,0, 1,2'b10));
        tbl.push_back(mk(0,4'h0,0,0,1,4'h9,0,0,0, 4'b1001,0,4'b1011,0, 0,2'b10));
        tbl.push_back(mk(0,4'h0,0,0,0,4'h0,0,1,0, 4'b1001,0,4'b1001,0, 0,2'b10));
        tbl.push_back(mk(1,4'hE,1,1,1,4'h6,0,0,0, 4'b0110,0,4'b1001,0, 0,2'b10));
        tbl.push_back(mk(0,4'h0,1,1,1,4'hF,0,0,1, 4'b0110,0,4'b0110,0, 0,2'b10));
        tbl.push_back(mk(0,4'h0,0,0,0,4'h0,0,0,0, 4'b1001,0,4'b1001,0, 0,2'b10));
        tbl.push_back(mk(0,4'h0,1,1,1,4'h3,0,0,0, 4'b0011,0,4'b1001,0, 0,2'b10));
        tbl.push_back(mk(0,4'h0,0,0,0,4'h0,0,1,1, 4'b0011,0,4'b0011,0, 0,2'b10));
        tbl.push_back(mk(0,4'h0,0,0,0,4'h0,0,0,0, 4'b1001,0,4'b1001,0, 0,2'b10));
        tbl.push_back(mk(0,4'h0,0,0,0,4'h0,0,0,1, 4'b1001,0,4'b1001,0, 0,2'b10));
        tbl.push_back(mk(0,4'h0,0,0,0,4'h0,0,0,0, 4'b0011,0,4'b0011,0, 0,2'b10));
        tbl.push_back(mk(0,4'h0,1,1,1,4'h5,0,1,0, 4'b0101,0,4'b0011,0, 0,2'b10));
        tbl.push_back(mk(0,4'h0,0,0,0,4'h0,0,0,1, 4'b0101,0,4'b0101,0, 0,2'b10));
        tbl.push_back(mk(0,4'h0,0,0,0,4'h0,0,0,0, 4'b0101,0,4'b0011,0, 0,2'b10));
        tbl.push_back(mk(0,4'h0,0,0,1,4'hC,0,0,0, 4'b1100,0,4'b0011,0, 0,2'b11));
        tbl.push_back(mk(0,4'h0,0,0,0,4'h0,0,0,0, 4'b1100,0,4'b1100,0, 0,2'b11));

        // Reset held with live EX write and a conditional in ID
        rst_n = 1'b0;
        t = mk(1,4'h0,0,0,1,4'hF,0,0,0, 4'h0,0,4'h0,0, 0,2'b00);
        drive(t);
        #12;
        chk("rst byp_out", b_out, 4'b0000);
        chk("rst reg_out", r_out, 4'b0000);
        chk("rst byp_stall", {3'b0, b_stall}, 4'b0000);
        chk("rst byp_pend", {2'b0, b_pend}, 4'b0000);
        chk("rst byp_err", {2'b0, b_err}, 4'b0000);
        t = mk(0,4'h0,0,0,0,4'h0,0,0,0, 4'h0,0,4'h0,0, 0,2'b00);
        drive(t);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[k]) apply(tbl[k], k);

        // Async reset mid-cycle with one setter in flight
        apply(mk(1,4'hE,1,1,0,4'h0,0,0,0, 4'b1100,0,4'b1100,0, 1,2'b11), 100);
        @(negedge clk);
        drive(mk(1,4'h0,0,0,1,4'hF,0,0,0, 4'h0,0,4'h0,0, 0,2'b00));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst byp_out", b_out, 4'b0000);
        chk("arst reg_out", r_out, 4'b0000);
        chk("arst byp_stall", {3'b0, b_stall}, 4'b0000);
        chk("arst reg_stall", {3'b0, r_stall}, 4'b0000);
        chk("arst byp_pend", {2'b0, b_pend}, 4'b0000);
        chk("arst reg_pend", {2'b0, r_pend}, 4'b0000);
        chk("arst byp_err", {2'b0, b_err}, 4'b0000);
        chk("arst reg_err", {2'b0, r_err}, 4'b0000);
        drive(mk(0,4'h0,0,0,0,4'h0,0,0,0, 4'h0,0,4'h0,0, 0,2'b00));
        @(negedge clk);
        rst_n = 1'b1;

        // First edges after release behave as from idle
        apply(mk(1,4'hE,1,1,0,4'h0,0,0,0, 4'b0000,0,4'b0000,0, 1,2'b00), 101);
        apply(mk(1,4'hA,0,0,0,4'h0,0,0,0, 4'b0000,1,4'b0000,1, 1,2'b00), 102);
        apply(mk(1,4'hA,0,0,1,4'h7,0,0,0, 4'b0111,0,4'b0000,1, 0,2'b00), 103);
        apply(mk(1,4'hA,0,0,0,4'h0,0,0,0, 4'b0111,0,4'b0111,0, 0,2'b00), 104);

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: got %0d left expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/status_flag_unit.md
STATUS_FLAG_UNIT -- requirements
Module: status_flag_unit

Interface
REQ-001 Parameter DEPTH, default 3: maximum number of in-flight flag-setting instructions tracked.
REQ-002 Parameter BYPASS, default 1: 1 = EX flag result forwarded to status_out in the same cycle; 0 = registered value only.
REQ-003 Clocking: one clock, clk; reset rst_n is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 id_valid  in  1  ID stage holds a valid instruction.
REQ-007 id_cond  in  4  condition field of the ID instruction.
REQ-008 id_issue  in  1  ID instruction advances to EX this cycle.
REQ-009 id_s  in  1  ID instruction sets flags (S bit).
REQ-010 ex_wr  in  1  EX instruction with S bit completes this cycle; its flags are valid.
REQ-011 ex_status  in  4  {N,Z,C,V} produced by the ALU.
REQ-012 flush  in  1  squash all in-flight instructions younger than ID.
REQ-013 save_req  in  1  copy the current flags to the shadow register (exception entry).
REQ-014 restore_req  in  1  copy the shadow register to the flags (exception return).
REQ-015 status_out  out  4  {N,Z,C,V} presented to the condition-check stage.
REQ-016 stall  out  1  hold ID: the condition cannot yet be evaluated.
REQ-017 pending  out  log2(DEPTH+1)  count of in-flight flag setters.
REQ-018 err  out  2  sticky flags {overflow, underflow}.

Function
REQ-019 The flag register nzcv SHALL load ex_status on the rising edge when ex_wr=1 and restore_req=0.
REQ-020 When restore_req=1, nzcv SHALL load shadow on the edge; a concurrent ex_wr SHALL be discarded.
REQ-021 When save_req=1, shadow SHALL load status_out (the post-bypass value); save and restore in the same cycle SHALL swap nzcv and shadow.
REQ-022 When BYPASS=1, status_out SHALL equal (ex_wr & ~restore_req) ? ex_status : nzcv, combinationally.
REQ-023 When BYPASS=0, status_out SHALL equal nzcv.
REQ-024 The pending count SHALL update as pending_next = pending + (id_issue & id_s) - ex_wr.
REQ-025 When flush=1, pending SHALL become 0 on the edge; id_issue in that cycle is ignored; ex_wr still updates nzcv.
REQ-026 Overflow: an increment at pending=DEPTH with no concurrent ex_wr SHALL hold pending at DEPTH and set err[1].
REQ-027 Underflow: ex_wr at pending=0 with no concurrent issue SHALL hold pending at 0, set err[0], and still write nzcv.
REQ-028 Define eff = pending - (BYPASS & ex_wr).
REQ-029 stall SHALL be 1 iff id_valid=1, id_cond != 4'b1110 (AL), and eff != 0; stall is combinational.
REQ-030 The unit SHALL NOT gate id_issue itself; the pipeline drives id_issue=0 while stall=1.
REQ-031 err bits SHALL remain set until reset.
REQ-032 Latency: flags written at edge k are visible on status_out from cycle k+1, or in cycle k when BYPASS=1.

Reset
REQ-033 While rst_n=0 the unit SHALL hold nzcv=0, shadow=0, pending=0, err=0, status_out=0, and stall=0.
REQ-034 Reset SHALL take effect asynchronously mid-operation, discarding in-flight counts; the first edge after deassertion behaves as from the idle state.

Verification
REQ-035 Issue one ADDS (id_issue=1, id_s=1), then ID holds BEQ (id_cond=0000) with pending=1 -> stall=1. Next cycle ex_wr=1, ex_status=0100 -> BYPASS=1: stall=0 and status_out=0100 in that cycle. BYPASS=0: stall=1 for one more cycle.
REQ-036 Issue three flag setters back-to-back with DEPTH=3 -> pending=3. A fourth issue without ex_wr -> pending=3, err=2'b10.
REQ-037 Pending=2, then flush=1 with id_issue=1, id_s=1 -> pending=0 next cycle; ID AL instruction -> stall=0.
REQ-038 nzcv=1001, then save_req=1; next cycle ex_wr with ex_status=0110; then restore_req=1 with ex_wr=1, ex_status=1111 -> nzcv=1001 and the ex_wr is discarded.
REQ-039 ex_wr=1 at pending=0 -> err=2'b01, pending=0, and nzcv updated. Assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately.
